// File: rtl/pll_reconfig_ctrl.sv
// Sequences the rPLL: applies IDSEL/FBDSEL/ODSEL, pulses its reset, waits for a filtered
// lock and only then releases the reset for PLL-clocked logic. Retries, then faults, on lock timeout.
// Ports: clk/rst (board clock, async active-high reset); req_i + req_*sel_i (reconfigure request,
//   taken only while ready_o=1); pll_lock_i (async LOCK); pll_reset_o and *sel_o drive the rPLL;
//   out_rst_o holds downstream logic in reset; ready_o/done_o/fault_o/retry_cnt_o report status.
// Latency: lock decisions see pll_lock_i two cycles late through the synchroniser. No request queueing.
module pll_reconfig_ctrl #(
  parameter int unsigned RST_HOLD     = 16,
  parameter int unsigned LOCK_STABLE  = 256,
  parameter int unsigned LOCK_TIMEOUT = 65535,
  parameter int unsigned MAX_RETRY    = 3,
  parameter logic [5:0]  DEF_IDSEL    = 6'd0,
  parameter logic [5:0]  DEF_FBDSEL   = 6'd0,
  parameter logic [5:0]  DEF_ODSEL    = 6'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_i,
  input  logic [5:0] req_idsel_i,
  input  logic [5:0] req_fbdsel_i,
  input  logic [5:0] req_odsel_i,
  input  logic       pll_lock_i,
  output logic       pll_reset_o,
  output logic [5:0] idsel_o,
  output logic [5:0] fbdsel_o,
  output logic [5:0] odsel_o,
  output logic       out_rst_o,
  output logic       ready_o,
  output logic       done_o,
  output logic       fault_o,
  output logic [2:0] retry_cnt_o
);

  localparam int HW = $clog2(RST_HOLD + 1);
  localparam int SW = $clog2(LOCK_STABLE + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);

  typedef enum logic [1:0] {S_HOLD, S_WAIT, S_RUN, S_FAULT} state_t;

  state_t        state_q;
  logic          lock_m_q, lock_s_q;
  logic [HW-1:0] hcnt_q;
  logic [SW-1:0] stab_q, stab_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          pll_reset_q, out_rst_q, ready_q, done_q, fault_q;
  logic [2:0]    retry_cnt_q;
  logic [5:0]    idsel_q, fbdsel_q, odsel_q;
  logic          accept;

  // Two-flop synchroniser: LOCK comes from the PLL and is asynchronous to clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_m_q <= 1'b0;
      lock_s_q <= 1'b0;
    end else begin
      lock_m_q <= pll_lock_i;
      lock_s_q <= lock_m_q;
    end
  end

  // Saturating next values for the WAIT counters; any low lock sample restarts the stable run.
  always_comb begin
    stab_d = '0;
    if (lock_s_q) stab_d = (stab_q >= SW'(LOCK_STABLE)) ? stab_q : stab_q + SW'(1);
    tmo_d = (tmo_q >= TW'(LOCK_TIMEOUT)) ? tmo_q : tmo_q + TW'(1);
  end

  assign accept = ready_q & req_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_HOLD;
      hcnt_q      <= '0;
      stab_q      <= '0;
      tmo_q       <= '0;
      pll_reset_q <= 1'b1;
      out_rst_q   <= 1'b1;
      ready_q     <= 1'b0;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
      retry_cnt_q <= 3'd0;
      idsel_q     <= DEF_IDSEL;
      fbdsel_q    <= DEF_FBDSEL;
      odsel_q     <= DEF_ODSEL;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        // New settings are loaded on the same edge the PLL goes back into reset,
        // so the PLL never sees a divider change while it is trying to lock.
        idsel_q     <= req_idsel_i;
        fbdsel_q    <= req_fbdsel_i;
        odsel_q     <= req_odsel_i;
        retry_cnt_q <= 3'd0;
        fault_q     <= 1'b0;
        state_q     <= S_HOLD;
        pll_reset_q <= 1'b1;
        out_rst_q   <= 1'b1;
        ready_q     <= 1'b0;
        hcnt_q      <= '0;
        stab_q      <= '0;
        tmo_q       <= '0;
      end else begin
        case (state_q)
          S_HOLD: begin
            if (hcnt_q >= HW'(RST_HOLD - 1)) begin
              state_q     <= S_WAIT;
              pll_reset_q <= 1'b0;
              hcnt_q      <= '0;
            end else begin
              hcnt_q <= hcnt_q + HW'(1);
            end
          end
          S_WAIT: begin
            stab_q <= stab_d;
            tmo_q  <= tmo_d;
            // Lock is tested first so it wins a tie with the timeout.
            if (stab_d >= SW'(LOCK_STABLE)) begin
              state_q   <= S_RUN;
              out_rst_q <= 1'b0;
              ready_q   <= 1'b1;
              done_q    <= 1'b1;
            end else if (tmo_d >= TW'(LOCK_TIMEOUT)) begin
              stab_q      <= '0;
              tmo_q       <= '0;
              pll_reset_q <= 1'b1;
              if (retry_cnt_q < 3'(MAX_RETRY)) begin
                retry_cnt_q <= retry_cnt_q + 3'd1;
                state_q     <= S_HOLD;
              end else begin
                state_q <= S_FAULT;
                fault_q <= 1'b1;
                ready_q <= 1'b1;
              end
            end
          end
          S_RUN: begin
            // Lost lock: fence downstream logic at once and try to reacquire without a PLL reset.
            if (!lock_s_q) begin
              state_q   <= S_WAIT;
              out_rst_q <= 1'b1;
              ready_q   <= 1'b0;
              stab_q    <= '0;
              tmo_q     <= '0;
            end
          end
          S_FAULT: begin
            // Parked with the PLL in reset until a new request arrives.
          end
          default: state_q <= S_HOLD;
        endcase
      end
    end
  end

  assign pll_reset_o = pll_reset_q;
  assign idsel_o     = idsel_q;
  assign fbdsel_o    = fbdsel_q;
  assign odsel_o     = odsel_q;
  assign out_rst_o   = out_rst_q;
  assign ready_o     = ready_q;
  assign done_o      = done_q;
  assign fault_o     = fault_q;
  assign retry_cnt_o = retry_cnt_q;

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// Bench for pll_reconfig_ctrl: directed vector table, hand-written corner sequences, then random
// lock/request/reset traffic, all checked every cycle against a behavioural model of the controller.
module tb_pll_reconfig_ctrl;

  localparam int RST_HOLD     = 16;
  localparam int LOCK_STABLE  = 256;
  // Long enough that the lock-latency scenarios finish inside one attempt.
  localparam int LOCK_TIMEOUT = 1000;
  localparam int MAX_RETRY    = 2;
  localparam logic [5:0] DEF_ID = 6'd1;
  localparam logic [5:0] DEF_FB = 6'd2;
  localparam logic [5:0] DEF_OD = 6'd4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req = 1'b0;
  logic [5:0] req_idsel = '0, req_fbdsel = '0, req_odsel = '0;
  logic       lock = 1'b0;
  logic       pll_reset, out_rst, ready, done, fault;
  logic [5:0] idsel, fbdsel, odsel;
  logic [2:0] retry_cnt;

  int checks = 0;
  int failures = 0;

  pll_reconfig_ctrl #(
    .RST_HOLD(RST_HOLD), .LOCK_STABLE(LOCK_STABLE), .LOCK_TIMEOUT(LOCK_TIMEOUT),
    .MAX_RETRY(MAX_RETRY), .DEF_IDSEL(DEF_ID), .DEF_FBDSEL(DEF_FB), .DEF_ODSEL(DEF_OD)
  ) dut (
    .clk(clk), .rst(rst), .req_i(req),
    .req_idsel_i(req_idsel), .req_fbdsel_i(req_fbdsel), .req_odsel_i(req_odsel),
    .pll_lock_i(lock), .pll_reset_o(pll_reset),
    .idsel_o(idsel), .fbdsel_o(fbdsel), .odsel_o(odsel),
    .out_rst_o(out_rst), .ready_o(ready), .done_o(done), .fault_o(fault),
    .retry_cnt_o(retry_cnt)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // The controller is described by "how much reset pulse is left", "how long we have waited",
  // "how long lock has been continuously seen", plus running/faulted flags.
  int   m_hold_left, m_age, m_run, m_retries;
  bit   m_running, m_faulted, m_done;
  bit   m_s1, m_s2;
  logic [5:0] m_id, m_fb, m_od;

  task automatic model_reset();
    m_hold_left = RST_HOLD; m_age = 0; m_run = 0; m_retries = 0;
    m_running = 0; m_faulted = 0; m_done = 0; m_s1 = 0; m_s2 = 0;
    m_id = DEF_ID; m_fb = DEF_FB; m_od = DEF_OD;
  endtask

  task automatic model_step();
    bit ls;
    ls = m_s2;              // lock as seen two edges ago
    m_s2 = m_s1;
    m_s1 = lock;
    m_done = 0;
    if ((m_running || m_faulted) && req) begin
      m_id = req_idsel; m_fb = req_fbdsel; m_od = req_odsel;
      m_retries = 0; m_faulted = 0; m_running = 0;
      m_hold_left = RST_HOLD; m_age = 0; m_run = 0;
    end else if (m_hold_left > 0) begin
      m_hold_left--; m_age = 0; m_run = 0;
    end else if (m_running) begin
      if (!ls) begin m_running = 0; m_age = 0; m_run = 0; end
    end else if (!m_faulted) begin
      m_age++;
      m_run = ls ? m_run + 1 : 0;
      if (m_run >= LOCK_STABLE) begin
        m_running = 1; m_done = 1;
      end else if (m_age >= LOCK_TIMEOUT) begin
        m_age = 0; m_run = 0;
        if (m_retries < MAX_RETRY) begin m_retries++; m_hold_left = RST_HOLD; end
        else m_faulted = 1;
      end
    end
  endtask

  task automatic check_all(string name);
    logic [25:0] act, exp;
    act = {pll_reset, out_rst, ready, done, fault, retry_cnt, idsel, fbdsel, odsel};
    exp = {(m_hold_left > 0) || m_faulted, !m_running, m_running || m_faulted, m_done,
           m_faulted, 3'(m_retries), m_id, m_fb, m_od};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%h want=%h (prst,orst,rdy,done,fault,retry,id,fb,od)",
               name, $time, act, exp);
    end
  endtask

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock: DUT and model advance on the posedge, outputs compared at the negedge.
  task automatic tick();
    @(posedge clk);
    if (rst) model_reset(); else model_step();
    @(negedge clk);
    check_all("lockstep");
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req = 1'b0;
    model_reset();
    #1 check_all("reset_now");
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    int         n;
    bit         lock;
    bit         req;
    logic [5:0] id, fb, od;
    bit         e_prst, e_orst, e_rdy, e_done;
    logic [5:0] e_id, e_fb, e_od;
  } vec_t;

  function automatic vec_t mk(int n, bit lk, bit rq, logic [5:0] id, logic [5:0] fb, logic [5:0] od,
                              bit prst, bit orst, bit rdy, bit dn,
                              logic [5:0] eid, logic [5:0] efb, logic [5:0] eod);
    vec_t v;
    v.n = n; v.lock = lk; v.req = rq; v.id = id; v.fb = fb; v.od = od;
    v.e_prst = prst; v.e_orst = orst; v.e_rdy = rdy; v.e_done = dn;
    v.e_id = eid; v.e_fb = efb; v.e_od = eod;
    return v;
  endfunction

  initial begin
    vec_t tbl[$];
    int   n, falls;
    bit   prev, seen;
    int   lock_left;

    // Power-up (lock rises after edge 39, locks at the 258th edge) then a 3/9/8 reconfiguration.
    tbl.push_back(mk( 15, 0, 0, 0, 0, 0, 1, 1, 0, 0, DEF_ID, DEF_FB, DEF_OD));
    tbl.push_back(mk(  1, 0, 0, 0, 0, 0, 0, 1, 0, 0, DEF_ID, DEF_FB, DEF_OD));
    tbl.push_back(mk( 23, 0, 0, 0, 0, 0, 0, 1, 0, 0, DEF_ID, DEF_FB, DEF_OD));
    tbl.push_back(mk(257, 1, 0, 0, 0, 0, 0, 1, 0, 0, DEF_ID, DEF_FB, DEF_OD));
    tbl.push_back(mk(  1, 1, 0, 0, 0, 0, 0, 0, 1, 1, DEF_ID, DEF_FB, DEF_OD));
    tbl.push_back(mk(  1, 1, 0, 0, 0, 0, 0, 0, 1, 0, DEF_ID, DEF_FB, DEF_OD));
    tbl.push_back(mk(  1, 1, 1, 3, 9, 8, 1, 1, 0, 0, 6'd3, 6'd9, 6'd8));
    tbl.push_back(mk( 15, 1, 0, 0, 0, 0, 1, 1, 0, 0, 6'd3, 6'd9, 6'd8));
    tbl.push_back(mk(  1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 6'd3, 6'd9, 6'd8));
    tbl.push_back(mk(255, 1, 0, 0, 0, 0, 0, 1, 0, 0, 6'd3, 6'd9, 6'd8));
    tbl.push_back(mk(  1, 1, 0, 0, 0, 0, 0, 0, 1, 1, 6'd3, 6'd9, 6'd8));

    // Reset state while rst is held.
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_pll_reset", pll_reset, 1);
    chk("rst_out_rst", out_rst, 1);
    chk("rst_ready", ready, 0);
    chk("rst_done_fault", {done, fault}, 0);
    chk("rst_retry", retry_cnt, 0);
    chk("rst_sel", {idsel, fbdsel, odsel}, {DEF_ID, DEF_FB, DEF_OD});
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      lock = tbl[i].lock; req = tbl[i].req;
      req_idsel = tbl[i].id; req_fbdsel = tbl[i].fb; req_odsel = tbl[i].od;
      repeat (tbl[i].n) tick();
      chk($sformatf("vec%0d", i),
          {pll_reset, out_rst, ready, done, idsel, fbdsel, odsel},
          {tbl[i].e_prst, tbl[i].e_orst, tbl[i].e_rdy, tbl[i].e_done, tbl[i].e_id, tbl[i].e_fb, tbl[i].e_od});
    end

    // Timeout with lock stuck low: three attempts, then FAULT.
    lock = 1'b0;
    do_reset();
    n = 0; falls = 0; prev = pll_reset;
    while (!fault && n < 5000) begin
      tick(); n++;
      if (prev && !pll_reset) falls++;
      prev = pll_reset;
    end
    chk("t3_fault_cycle", n, 3 * (RST_HOLD + LOCK_TIMEOUT));
    chk("t3_attempts", falls, 3);
    chk("t3_retry", retry_cnt, MAX_RETRY);
    chk("t3_fault_state", {fault, pll_reset, out_rst, ready, done}, 5'b11110);

    // A new request clears the fault and loads settings on the same edge.
    req = 1'b1; req_idsel = 6'd5; req_fbdsel = 6'd17; req_odsel = 6'd33; lock = 1'b1;
    tick();
    req = 1'b0;
    chk("t3_clear", {fault, ready, pll_reset, retry_cnt}, {1'b0, 1'b0, 1'b1, 3'd0});
    chk("t3_sel", {idsel, fbdsel, odsel}, {6'd5, 6'd17, 6'd33});

    // Glitch at stab=200: the stable run restarts, relock 258 edges after the pin returns high.
    repeat (RST_HOLD + 200) tick();
    chk("t4_pre_glitch", out_rst, 1);
    lock = 1'b0;
    tick();
    lock = 1'b1;
    n = 0;
    while (out_rst && n < 600) begin tick(); n++; end
    chk("t4_relock", n, LOCK_STABLE + 2);
    chk("t4_done", done, 1);

    // Lock loss in RUN: downstream reset within 3 cycles, no PLL reset, relock without retries.
    tick();
    lock = 1'b0;
    n = 0; seen = 0;
    while (!out_rst && n < 10) begin tick(); n++; seen |= pll_reset; end
    chk("t5_orst_latency", n, 3);
    repeat (5 - n) begin tick(); seen |= pll_reset; end
    lock = 1'b1;
    n = 0;
    while (!done && n < 1000) begin tick(); n++; seen |= pll_reset; end
    chk("t5_relock", n, LOCK_STABLE + 2);
    chk("t5_no_pll_reset", seen, 0);
    chk("t5_retry", retry_cnt, 0);

    // Request while busy is ignored; reset mid-WAIT takes effect immediately.
    tick();
    req = 1'b1; req_idsel = 6'd10; req_fbdsel = 6'd20; req_odsel = 6'd30;
    tick();
    req_idsel = 6'd40; req_fbdsel = 6'd50; req_odsel = 6'd60;
    repeat (RST_HOLD + 5) tick();
    req = 1'b0;
    chk("t6_in_wait", {pll_reset, ready}, 0);
    chk("t6_sel_kept", {idsel, fbdsel, odsel}, {6'd10, 6'd20, 6'd30});
    rst = 1'b1;
    model_reset();
    #1;
    chk("t6_rst_outputs", {pll_reset, out_rst, ready, done, fault, retry_cnt}, 8'b1100_0000);
    chk("t6_rst_sel", {idsel, fbdsel, odsel}, {DEF_ID, DEF_FB, DEF_OD});
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    while (pll_reset && n < 100) begin n++; tick(); end
    chk("t6_hold_len", n, RST_HOLD);

    // Random traffic against the model.
    lock_left = 0;
    for (int i = 0; i < 12000; i++) begin
      if (lock_left == 0) begin
        lock = ($urandom_range(0, 3) != 0);
        if (lock) lock_left = $urandom_range(50, 600);
        else if ($urandom_range(0, 7) == 0) lock_left = $urandom_range(1000, 2500);
        else lock_left = $urandom_range(1, 40);
      end
      lock_left--;
      req = ($urandom_range(0, 31) == 0);
      req_idsel = 6'($urandom_range(0, 63));
      req_fbdsel = 6'($urandom_range(0, 63));
      req_odsel = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 2999) == 0) begin
        rst = 1'b1;
        model_reset();
        #1 check_all("rand_rst");
        @(negedge clk);
        rst = 1'b0;
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
